mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a single 4:1 bit mux between four requesters.
- Selects one requester per cycle and drives its one-hot grant and the 2-bit mux select (s1,s0).
- Registers the selected data bit with a valid flag.
- A bounded hold counter stops one requester from monopolising the mux while others wait.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles for one owner while other requests are pending. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per requester; bit i = requester i
- d  input  4  data bit per requester; d[i] is mux input i
- grant  output  4  registered one-hot grant; 0000 when idle
- sel  output  2  registered mux select {s1,s0}, equal to the owner index; 00 when idle
- busy  output  1  registered; 1 while in state GRANT
- dout  output  1  registered mux output
- dout_vld  output  1  registered; 1 when dout carries a granted sample

Behaviour:
- Internal state:
  - state: IDLE or GRANT
  - owner: 2-bit owner index
  - last: 2-bit index of the last released owner
  - hold_cnt: 4-bit hold counter
- Reset (rst=1 at an edge), overriding everything including a mid-grant owner:
  - state=IDLE, owner=0, last=3, hold_cnt=0
  - grant=0000, sel=00, busy=0, dout=0, dout_vld=0
- rr_pick(mask, ptr): returns the first set bit of mask, scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
- IDLE:
  - If req≠0: owner<=rr_pick(req,last), hold_cnt<=1, state<=GRANT.
  - Otherwise remain in IDLE.
- GRANT: let others = req & ~onehot(owner).
  - Release occurs if req[owner]=0, or if hold_cnt==MAX_HOLD and others≠0. On release: last<=owner, then:
    - if others≠0: owner<=rr_pick(others,owner), hold_cnt<=1, stay in GRANT. No idle bubble between owners.
    - else: state<=IDLE, grant/sel/busy go to 0/00/0 at the same edge.
  - Else if hold_cnt==MAX_HOLD with others=0: hold_cnt<=1; the owner keeps the grant.
  - Else: hold_cnt<=hold_cnt+1.
- Output timing:
  - grant, sel and busy reflect the next-state owner at the same edge that state updates.
  - Request-to-grant latency is 1 cycle.
- Data path:
  - Each edge: dout<=busy ? d[sel] : 0 and dout_vld<=busy, using the pre-edge grant.
  - A sample therefore appears 1 cycle after the grant cycle it belongs to. Grant-to-data latency is 1.
- Boundary conditions:
  - Simultaneous drop of req[owner] and a new request: the new request is arbitrated at the same edge.
  - Owner index wraps 3→0.
  - MAX_HOLD=1 gives per-cycle rotation under contention.
  - Requests that assert and drop while not granted are never latched.
- Invariants:
  - grant is always 0000 or one-hot.
  - sel equals the index of the set grant bit.
  - grant≠0 exactly when busy=1.

Test Plan:
- Directed grant and data: after reset, req=0001, d=0001.
  - Next edge: grant=0001, sel=00, busy=1.
  - Following edge: dout=1, dout_vld=1.
- Full contention: MAX_HOLD=4, req=1111 held.
  - Grant sequence is 0001×4, 0010×4, 0100×4, 1000×4, then 0001.
  - sel tracks 00, 01, 10, 11.
- Owner drop: owner 0 with req=0101, then drop req[0].
  - Next edge: grant=0100, no cycle with busy=0.
  - If req drops to 0000 instead: grant=0000, busy=0, dout_vld=0 one edge later.
- Sole requester: req=0100 for 10 cycles.
  - grant=0100 on all 10 cycles with no bubble.
  - hold_cnt wraps 4→1 internally.
- Reset mid-grant: rst=1 while grant=0010.
  - Next edge: grant=0000, sel=00, busy=0, dout=0, dout_vld=0.
  - After rst=0 and req=1010: grant=0010, because last=3 after reset so index 0 is scanned first.
- Mux data fidelity: owner 3 with MAX_HOLD=15, d toggling 1000/0000 each cycle.
  - dout follows d[3] delayed one cycle.
  - Changes on d[0..2] never affect dout.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux between four requesters.
// A bounded hold counter forces rotation when the owner has held the mux for
// MAX_HOLD cycles while others are waiting; the selected bit is registered
// with a valid flag one cycle after the grant it belongs to.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       dout,
  output logic       dout_vld
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] MaxHoldCnt = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       dout_q, dout_d;
  logic       dout_vld_q, dout_vld_d;

  logic [3:0] others;
  logic       at_max;

  // First set bit of mask scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Arbitration next-state: owner selection, hold counting and release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    others     = req & ~(4'b0001 << owner_q);
    at_max     = (hold_cnt_q == MaxHoldCnt);
    unique case (state_q)
      StIdle: begin
        if (req != 4'b0000) begin
          owner_d    = rr_pick(req, last_q);
          hold_cnt_d = 4'd1;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (!req[owner_q] || (at_max && others != 4'b0000)) begin
          last_d = owner_q;
          if (others != 4'b0000) begin
            // Hand over directly so there is no idle bubble between owners.
            owner_d    = rr_pick(others, owner_q);
            hold_cnt_d = 4'd1;
          end else begin
            state_d = StIdle;
          end
        end else if (at_max) begin
          // Nobody else waiting: owner keeps the mux, counter restarts.
          hold_cnt_d = 4'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs follow the next-state owner; data uses the pre-edge grant.
  always_comb begin
    grant_d    = 4'b0000;
    sel_d      = 2'b00;
    busy_d     = 1'b0;
    if (state_d == StGrant) begin
      grant_d = 4'b0001 << owner_d;
      sel_d   = owner_d;
      busy_d  = 1'b1;
    end
    dout_d     = busy_q ? d[sel_q] : 1'b0;
    dout_vld_d = busy_q;
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 2'd0;
      last_q     <= 2'd3;
      hold_cnt_q <= 4'd0;
      grant_q    <= 4'b0000;
      sel_q      <= 2'b00;
      busy_q     <= 1'b0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with three hold limits sharing one stimulus.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;

  logic [3:0] grant4, grant1, grant15;
  logic [1:0] sel4, sel1, sel15;
  logic       busy4, busy1, busy15;
  logic       dout4, dout1, dout15;
  logic       vld4, vld1, vld15;

  int checks;
  int failures;

  mux_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .grant(grant4), .sel(sel4), .busy(busy4), .dout(dout4), .dout_vld(vld4)
  );

  mux_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .grant(grant1), .sel(sel1), .busy(busy1), .dout(dout1), .dout_vld(vld1)
  );

  mux_rr_arbiter #(.MAX_HOLD(15)) u_dut15 (
    .clk(clk), .rst(rst), .req(req), .d(d),
    .grant(grant15), .sel(sel15), .busy(busy15), .dout(dout15), .dout_vld(vld15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are changed only after this.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    d   = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant4, sel4, busy4, dout4, vld4} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs: got grant=%b sel=%b busy=%b dout=%b vld=%b, want all zero",
               grant4, sel4, busy4, dout4, vld4);
    end
  endtask

  task automatic test_grant_data();
    do_reset();
    req = 4'b0001;
    d   = 4'b0001;
    step();
    checks++;
    if ({grant4, sel4, busy4, vld4} !== {4'b0001, 2'b00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL first_grant: got grant=%b sel=%b busy=%b vld=%b, want 0001 00 1 0",
               grant4, sel4, busy4, vld4);
    end
    step();
    checks++;
    if ({dout4, vld4} !== 2'b11) begin
      failures++;
      $display("FAIL first_data: got dout=%b vld=%b, want 1 1", dout4, vld4);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_contention();
    logic [3:0] exp4, exp1;
    logic [1:0] idx4, idx1;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      step();
      idx4 = 2'((k / 4) % 4);
      idx1 = 2'(k % 4);
      exp4 = 4'b0001 << idx4;
      exp1 = 4'b0001 << idx1;
      checks++;
      if (grant4 !== exp4 || sel4 !== idx4 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL contention_hold4[%0d]: got grant=%b sel=%b busy=%b, want %b %b 1",
                 k, grant4, sel4, busy4, exp4, idx4);
      end
      checks++;
      if (grant1 !== exp1 || sel1 !== idx1) begin
        failures++;
        $display("FAIL contention_hold1[%0d]: got grant=%b sel=%b, want %b %b",
                 k, grant1, sel1, exp1, idx1);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 4'b0101;
    step();
    checks++;
    if (grant4 !== 4'b0001) begin
      failures++;
      $display("FAIL drop_setup: got grant=%b, want 0001", grant4);
    end
    req = 4'b0100;
    step();
    checks++;
    if (grant4 !== 4'b0100 || busy4 !== 1'b1 || sel4 !== 2'b10) begin
      failures++;
      $display("FAIL drop_handover: got grant=%b sel=%b busy=%b, want 0100 10 1",
               grant4, sel4, busy4);
    end
    req = 4'b0000;
    step();
    checks++;
    if (grant4 !== 4'b0000 || busy4 !== 1'b0 || vld4 !== 1'b1) begin
      failures++;
      $display("FAIL drop_idle: got grant=%b busy=%b vld=%b, want 0000 0 1",
               grant4, busy4, vld4);
    end
    step();
    checks++;
    if (vld4 !== 1'b0) begin
      failures++;
      $display("FAIL drop_vld_clear: got vld=%b, want 0", vld4);
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (grant4 !== 4'b0100 || sel4 !== 2'b10 || busy4 !== 1'b1) begin
        failures++;
        $display("FAIL sole[%0d]: got grant=%b sel=%b busy=%b, want 0100 10 1",
                 k, grant4, sel4, busy4);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010;
    d   = 4'b1111;
    step();
    step();
    checks++;
    if (grant4 !== 4'b0010) begin
      failures++;
      $display("FAIL mid_setup: got grant=%b, want 0010", grant4);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({grant4, sel4, busy4, dout4, vld4} !== 9'b0) begin
      failures++;
      $display("FAIL mid_reset: got grant=%b sel=%b busy=%b dout=%b vld=%b, want all zero",
               grant4, sel4, busy4, dout4, vld4);
    end
    rst = 1'b0;
    req = 4'b1010;
    step();
    checks++;
    if (grant4 !== 4'b0010 || sel4 !== 2'b01) begin
      failures++;
      $display("FAIL mid_rearb: got grant=%b sel=%b, want 0010 01", grant4, sel4);
    end
    req = 4'b0000;
    d   = 4'b0000;
    step();
  endtask

  task automatic test_data_fidelity();
    logic exp_bit;
    do_reset();
    req = 4'b1000;
    d   = 4'b1000;
    step();
    checks++;
    if (grant15 !== 4'b1000 || sel15 !== 2'b11) begin
      failures++;
      $display("FAIL data_setup: got grant=%b sel=%b, want 1000 11", grant15, sel15);
    end
    for (int k = 0; k < 8; k++) begin
      exp_bit = (k % 2 == 0);
      d = {exp_bit, 3'($urandom_range(7, 0))};
      step();
      checks++;
      if (dout15 !== exp_bit || vld15 !== 1'b1) begin
        failures++;
        $display("FAIL data[%0d]: got dout=%b vld=%b, want %b 1", k, dout15, vld15, exp_bit);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_unlatched_pulse();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0101;  // short pulse on requester 2 while 0 owns the mux
    step();
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    checks++;
    if (grant4 !== 4'b0000 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL unlatched: got grant=%b busy=%b, want 0000 0", grant4, busy4);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    d        = 4'b0000;
    test_reset();
    test_grant_data();
    test_contention();
    test_owner_drop();
    test_sole_requester();
    test_reset_mid_grant();
    test_data_fidelity();
    test_unlatched_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
